// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART TX/RX FIFO controller.
package uart_fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DEF = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 128;

    // Status bundle consumed by the TL-UL register block.
    typedef struct packed {
        logic full;
        logic empty;
        logic thresh_hit;
        logic ovf;
        logic udf;
    } fifo_status_t;

    // Width of level/threshold fields: one extra bit so DEPTH itself fits.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, no reset so it
// can later be swapped for an SRAM macro.
module uart_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 128,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Parametrised synchronous FIFO (controller + storage) for the UART data paths.
// Exact full/empty, fill level, watermark, sticky overflow/underflow.
// Optional macro UART_FIFO_FWFT_EN selects first-word fall-through reads;
// otherwise reads have one cycle of registered latency.
module uart_fifo_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned LVLW = lvl_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVLW-1:0]  level_o,
    input  logic [LVLW-1:0]  thresh_i,
    output logic             thresh_hit_o,
    output logic             ovf_o,
    output logic             udf_o
);

    localparam int unsigned AW = LVLW - 1;

    // Pointers carry a wrap bit above the address bits.
    logic [LVLW-1:0]  wptr_q, wptr_d;
    logic [LVLW-1:0]  rptr_q, rptr_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [LVLW-1:0]  level;
    logic             full, empty;
    logic             wa, ra;
    logic [WIDTH-1:0] mem_rdata;
    fifo_status_t     status;

    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty = (wptr_q == rptr_q);
    assign level = wptr_q - rptr_q;

    // A flush swallows any request issued in the same cycle.
    assign ra = ~clr_i & re_i & ~empty;
    assign wa = ~clr_i & we_i & (~full | ra);

    uart_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wa),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (wdata_i),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    // Pointer and sticky error next-state.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else begin
            if (wa) begin
                wptr_d = wptr_q + LVLW'(1);
            end
            if (ra) begin
                rptr_d = rptr_q + LVLW'(1);
            end
            if (we_i && !wa) begin
                ovf_d = 1'b1;
            end
            if (re_i && !ra) begin
                udf_d = 1'b1;
            end
        end
    end

    // Pointer and error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

`ifdef UART_FIFO_FWFT_EN
    // Head entry is shown directly; masked to zero while empty so the output
    // never exposes uninitialised storage.
    assign rdata_o  = empty ? '0 : mem_rdata;
    assign rvalid_o = ~empty;
`else
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    // Registered read: capture the head on an accepted read, hold otherwise.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = ra;
        if (ra) begin
            rdata_d = mem_rdata;
        end
    end

    // Read output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
`endif

    assign status.full       = full;
    assign status.empty      = empty;
    assign status.thresh_hit = (level >= thresh_i);
    assign status.ovf        = ovf_q;
    assign status.udf        = udf_q;

    assign full_o       = status.full;
    assign empty_o      = status.empty;
    assign thresh_hit_o = status.thresh_hit;
    assign ovf_o        = status.ovf;
    assign udf_o        = status.udf;
    assign level_o      = level;

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
- Parametrised synchronous FIFO controller plus storage for the UART TX/RX data paths; next generation of the fixed 128x8 buffer controller.
- Adds exact full/empty, true fill level, programmable watermark, sticky overflow/underflow errors and a registered read-data valid.
- One instance per direction between the UART shift engine and the TL-UL register block.

Parameters:
- WIDTH, 8, data word width in bits (1..32).
- DEPTH, 128, number of entries; power of two, >= 4.
- LVLW, $clog2(DEPTH)+1, width of level/threshold fields (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clr_i  in  1  synchronous flush; highest priority after reset
- we_i  in  1  write request
- wdata_i  in  WIDTH  write data
- re_i  in  1  read request
- rdata_o  out  WIDTH  read data
- rvalid_o  out  1  rdata_o holds data from an accepted read
- full_o  out  1  level == DEPTH
- empty_o  out  1  level == 0
- level_o  out  LVLW  current entry count, 0..DEPTH
- thresh_i  in  LVLW  watermark, quasi-static
- thresh_hit_o  out  1  level_o >= thresh_i (combinational from registered level)
- ovf_o  out  1  sticky: write attempted while full
- udf_o  out  1  sticky: read attempted while empty

Behaviour:
- Reset values: all pointers 0, level_o 0, empty_o 1, full_o 0, rvalid_o 0, rdata_o 0, ovf_o 0, udf_o 0.
- Pointers: wptr/rptr are LVLW bits wide; the low bits address the storage, the MSB is the wrap bit. They wrap naturally at 2*DEPTH.
- Status: full when the address bits are equal and the wrap bits differ; empty when the pointers are equal. level = wptr - rptr, modulo 2^LVLW.
- Write accept: wa = we_i & (~full_o | ra).
- Read accept: ra = re_i & ~empty_o.
- Full with we_i & re_i: both are accepted, level is unchanged, and the written word lands in the slot being freed.
- Empty with we_i & re_i: only the write is accepted. udf_o sets. The written word becomes readable next cycle.
- Rejected write: data dropped, pointers unchanged, ovf_o <= 1.
- Rejected read: pointers unchanged, udf_o <= 1, rvalid_o <= 0.
- Read latency (default): 1 cycle. The cycle after ra, rdata_o holds the entry and rvalid_o = 1 for exactly that cycle. rdata_o holds its value otherwise.
- clr_i: pointers to 0, ovf_o/udf_o to 0, rvalid_o to 0. Any we_i/re_i in the same cycle is ignored. Storage contents are not cleared.
- Sticky flags clear only on clr_i or reset.
- No FSM. Control is pointer/level counters plus the error and valid registers.
- Reset asserted mid-transfer: immediate return to the reset values. Storage contents are undefined afterwards.

Optional Feature:
- Macro UART_FIFO_FWFT_EN.
- Defined (first-word fall-through): rdata_o shows the head entry combinationally whenever ~empty_o, and rvalid_o = ~empty_o. re_i acts as a pop, with a 0-cycle read latency. A word written into an empty FIFO is visible the cycle after the write.
- Undefined: 1-cycle registered read as specified above.

Decomposition:
- Package uart_fifo_pkg:
  - localparam defaults: FIFO_WIDTH_DEF = 8, FIFO_DEPTH_DEF = 128.
  - typedef fifo_status_t: packed struct {full, empty, thresh_hit, ovf, udf}, used by the register block.
  - function lvl_w(depth) returning $clog2(depth)+1.
- Sub-module uart_fifo_mem: DEPTH x WIDTH register array with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr -> rdata). It has no reset, so it can later map to an SRAM macro.
- uart_fifo_ctrl holds all pointer, flag and output-register logic.

Test Plan:
- Reset, then write 0x01..0x80 (DEPTH=128) -> full_o=1 after the 128th write, level_o=128. A 129th write of 0xFF sets ovf_o=1 and level stays 128.
- Read 128 words from full -> rdata_o is 0x01..0x80 in order, each one cycle after re_i with rvalid_o=1. empty_o=1 after the last read. An extra re_i sets udf_o=1 and rvalid_o stays 0.
- Fill to 128, then assert we_i=1 (0xAA) and re_i=1 together -> read returns 0x01, level stays 128, and 0xAA is read last (128th) after draining.
- thresh_i=16; write 15 words -> thresh_hit_o=0. The 16th write -> thresh_hit_o=1 the next cycle. One read -> thresh_hit_o=0.
- Wrap-around: run 300 write/read pairs at level 3 -> data in order with no loss, level_o stays 3 and the pointer MSB toggles. Then clr_i -> level_o=0, empty_o=1, ovf_o=udf_o=0.
- With UART_FIFO_FWFT_EN defined: write 0x5A to an empty FIFO -> next cycle rdata_o=0x5A and rvalid_o=1 with no re_i. re_i -> empty_o=1 and rvalid_o=0 the next cycle.
